// File: rtl/cp0_reg.sv
// cp0_reg -- MIPS32 coprocessor-0 system control registers.
//
// Holds Count, Compare, Status, Cause, EPC, Config and PRId. It takes the
// CP0 write from the WB stage, the exception summary from MEM and the
// external interrupt lines, and it raises the timer interrupt. There are no
// valid/ready handshakes and no FSM. All state changes on the rising clk edge.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   we_i/waddr_i/data_i   CP0 write from WB (mtc0)
//   raddr_i -> data_o     combinational read for mfc0. Unmapped numbers read 0.
//   int_i                 external interrupt lines, sampled into Cause[15:10]
//   excepttype_i          MEM exception code (0 = none)
//   current_inst_addr_i   PC of the MEM instruction
//   is_in_delayslot_i     MEM instruction sits in a branch delay slot
//   *_o                   register contents; timer_int_o is registered
module cp0_reg #(
  parameter logic [31:0] PRID_VALUE   = 32'h004C0102,
  parameter logic [31:0] CONFIG_RESET = 32'h00008000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] data_i,
  input  logic [4:0]  raddr_i,
  input  logic [5:0]  int_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] current_inst_addr_i,
  input  logic        is_in_delayslot_i,
  output logic [31:0] data_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] config_o,
  output logic [31:0] prid_o,
  output logic        timer_int_o
);

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;
  localparam logic [4:0] REG_PRID    = 5'd15;
  localparam logic [4:0] REG_CONFIG  = 5'd16;

  localparam logic [31:0] STATUS_RESET = 32'h10000000;

  // Cause bits that software may write: IV[23], WP[22], IP[9:8].
  localparam logic [31:0] CAUSE_WMASK = 32'h00C00300;

  logic [31:0] count_q,   count_d;
  logic [31:0] compare_q, compare_d;
  logic [31:0] status_q,  status_d;
  logic [31:0] cause_q,   cause_d;
  logic [31:0] epc_q,     epc_d;
  logic [31:0] config_q,  config_d;
  logic        timer_int_q, timer_int_d;

  logic        exc_take;
  logic [4:0]  exc_code;
  logic        exc_eret;

  // Decode the MEM exception summary into "enter exception with code" or eret.
  always_comb begin
    exc_take = 1'b0;
    exc_code = 5'd0;
    exc_eret = 1'b0;
    case (excepttype_i)
      32'h0000_0001: begin exc_take = 1'b1; exc_code = 5'd0;  end
      32'h0000_0008: begin exc_take = 1'b1; exc_code = 5'd8;  end
      32'h0000_000a: begin exc_take = 1'b1; exc_code = 5'd10; end
      32'h0000_000d: begin exc_take = 1'b1; exc_code = 5'd13; end
      32'h0000_000c: begin exc_take = 1'b1; exc_code = 5'd12; end
      32'h0000_000e: exc_eret = 1'b1;
      default: ;
    endcase
  end

  // Next-state: increment/sample first, then the WB write, then the exception,
  // so that later assignments take priority over earlier ones.
  always_comb begin
    count_d     = count_q + 32'd1;
    compare_d   = compare_q;
    status_d    = status_q;
    cause_d     = cause_q;
    epc_d       = epc_q;
    config_d    = config_q;
    timer_int_d = timer_int_q;

    cause_d[15:10] = int_i;

    // Compare == 0 is the "timer off" value and never fires.
    if (compare_q != 32'd0 && count_q == compare_q) begin
      timer_int_d = 1'b1;
    end

    if (we_i) begin
      case (waddr_i)
        REG_COUNT:   count_d = data_i;
        REG_COMPARE: begin
          compare_d   = data_i;
          timer_int_d = 1'b0;   // acknowledge wins over a same-cycle match
        end
        REG_STATUS:  status_d = data_i;
        REG_CAUSE:   cause_d = (cause_d & ~CAUSE_WMASK) | (data_i & CAUSE_WMASK);
        REG_EPC:     epc_d = data_i;
        default: ;   // PRId, Config and unmapped numbers are read-only here
      endcase
    end

    if (exc_take) begin
      // Nested exceptions (EXL already set) keep the original EPC and BD.
      if (!status_q[1]) begin
        epc_d       = is_in_delayslot_i ? (current_inst_addr_i - 32'd4)
                                        : current_inst_addr_i;
        cause_d[31] = is_in_delayslot_i;
      end
      status_d[1]  = 1'b1;
      cause_d[6:2] = exc_code;
    end else if (exc_eret) begin
      status_d[1] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= 32'd0;
      compare_q   <= 32'd0;
      status_q    <= STATUS_RESET;
      cause_q     <= 32'd0;
      epc_q       <= 32'd0;
      config_q    <= CONFIG_RESET;
      timer_int_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      compare_q   <= compare_d;
      status_q    <= status_d;
      cause_q     <= cause_d;
      epc_q       <= epc_d;
      config_q    <= config_d;
      timer_int_q <= timer_int_d;
    end
  end

  // Read port shows register state only. Same-cycle writes are forwarded
  // outside this block.
  always_comb begin
    data_o = 32'd0;
    case (raddr_i)
      REG_COUNT:   data_o = count_q;
      REG_COMPARE: data_o = compare_q;
      REG_STATUS:  data_o = status_q;
      REG_CAUSE:   data_o = cause_q;
      REG_EPC:     data_o = epc_q;
      REG_PRID:    data_o = PRID_VALUE;
      REG_CONFIG:  data_o = config_q;
      default:     data_o = 32'd0;
    endcase
  end

  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign status_o    = status_q;
  assign cause_o     = cause_q;
  assign epc_o       = epc_q;
  assign config_o    = config_q;
  assign prid_o      = PRID_VALUE;
  assign timer_int_o = timer_int_q;

endmodule

// File: tb/tb_cp0_reg.sv
// tb_cp0_reg -- directed bench for cp0_reg with hand-computed expectations.
// Inputs are driven and outputs sampled on the falling edge of clk.
module tb_cp0_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] data_i;
  logic [4:0]  raddr_i;
  logic [5:0]  int_i;
  logic [31:0] excepttype_i;
  logic [31:0] current_inst_addr_i;
  logic        is_in_delayslot_i;
  logic [31:0] data_o, count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o;
  logic        timer_int_o;

  int n_checks = 0;
  int n_fail   = 0;

  // clock / reset
  always #5 clk = ~clk;

  cp0_reg dut (
    .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .data_i(data_i),
    .raddr_i(raddr_i), .int_i(int_i), .excepttype_i(excepttype_i),
    .current_inst_addr_i(current_inst_addr_i), .is_in_delayslot_i(is_in_delayslot_i),
    .data_o(data_o), .count_o(count_o), .compare_o(compare_o), .status_o(status_o),
    .cause_o(cause_o), .epc_o(epc_o), .config_o(config_o), .prid_o(prid_o),
    .timer_int_o(timer_int_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver: one-cycle CP0 write
  task automatic cp0_write(input logic [4:0] a, input logic [31:0] d);
    we_i = 1'b1; waddr_i = a; data_i = d;
    @(negedge clk);
    we_i = 1'b0; waddr_i = 5'd0; data_i = 32'd0;
  endtask

  // driver: one-cycle exception presentation
  task automatic raise_exc(input logic [31:0] t, input logic [31:0] pc, input logic ds);
    excepttype_i = t; current_inst_addr_i = pc; is_in_delayslot_i = ds;
    @(negedge clk);
    excepttype_i = 32'd0; current_inst_addr_i = 32'd0; is_in_delayslot_i = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [4:0] a, input logic [31:0] exp);
    raddr_i = a;
    #1;
    check(tag, data_o, exp);
  endtask

  initial begin
    rst = 1'b1; we_i = 1'b0; waddr_i = 5'd0; data_i = 32'd0; raddr_i = 5'd0;
    int_i = 6'd0; excepttype_i = 32'd0; current_inst_addr_i = 32'd0;
    is_in_delayslot_i = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_count",   count_o,   32'h0);
    check("rst_compare", compare_o, 32'h0);
    check("rst_status",  status_o,  32'h10000000);
    check("rst_cause",   cause_o,   32'h0);
    check("rst_epc",     epc_o,     32'h0);
    check("rst_config",  config_o,  32'h00008000);
    check("rst_prid",    prid_o,    32'h004C0102);
    check("rst_timer",   {31'd0, timer_int_o}, 32'd0);
    read_check("rst_rd_status", 5'd12, 32'h10000000);

    // idle after release: count runs, compare == 0 never fires
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_count", count_o, 32'd5);
    check("idle_status", status_o, 32'h10000000);
    check("idle_timer_cmp0", {31'd0, timer_int_o}, 32'd0);
    read_check("rd_prid",   5'd15, 32'h004C0102);
    read_check("rd_config", 5'd16, 32'h00008000);
    read_check("rd_count",  5'd9,  32'd5);
    read_check("rd_unmapped", 5'd20, 32'd0);

    // count load and wrap
    cp0_write(5'd9, 32'hFFFFFFFE);
    check("wrap0", count_o, 32'hFFFFFFFE);
    @(negedge clk); check("wrap1", count_o, 32'hFFFFFFFF);
    @(negedge clk); check("wrap2", count_o, 32'h0);
    @(negedge clk); check("wrap3", count_o, 32'h1);

    // timer: fires one edge after count == compare, holds until Compare written
    cp0_write(5'd11, 32'd20);
    cp0_write(5'd9, 32'd10);
    check("tmr_count10", count_o, 32'd10);
    check("tmr_compare", compare_o, 32'd20);
    repeat (10) @(negedge clk);
    check("tmr_count20", count_o, 32'd20);
    check("tmr_not_yet", {31'd0, timer_int_o}, 32'd0);
    @(negedge clk);
    check("tmr_rise", {31'd0, timer_int_o}, 32'd1);
    repeat (3) @(negedge clk);
    check("tmr_hold", {31'd0, timer_int_o}, 32'd1);
    cp0_write(5'd11, 32'd50);
    check("tmr_clear", {31'd0, timer_int_o}, 32'd0);
    check("tmr_compare50", compare_o, 32'd50);

    // Compare write beats a same-cycle match
    cp0_write(5'd11, 32'd100);
    cp0_write(5'd9, 32'd100);
    cp0_write(5'd11, 32'd300);
    check("tmr_clear_beats_match", {31'd0, timer_int_o}, 32'd0);

    // syscall in delay slot, EXL = 0
    raise_exc(32'h8, 32'h100, 1'b1);
    check("sys_epc",    epc_o,    32'hFC);
    check("sys_cause",  cause_o,  32'h80000020);
    check("sys_status", status_o, 32'h10000002);
    // overflow while EXL = 1: EPC/BD kept, code updated
    raise_exc(32'hc, 32'h200, 1'b0);
    check("ov_epc",    epc_o,    32'hFC);
    check("ov_cause",  cause_o,  32'h80000030);
    // eret clears EXL only
    raise_exc(32'he, 32'h0, 1'b0);
    check("eret_status", status_o, 32'h10000000);
    check("eret_cause",  cause_o,  32'h80000030);
    check("eret_epc",    epc_o,    32'hFC);
    // trap outside a delay slot
    raise_exc(32'hd, 32'h300, 1'b0);
    check("trap_epc",   epc_o,   32'h300);
    check("trap_cause", cause_o, 32'h00000034);
    raise_exc(32'he, 32'h0, 1'b0);
    // unknown code has no effect
    raise_exc(32'h5, 32'h500, 1'b1);
    check("unk_epc",    epc_o,    32'h300);
    check("unk_cause",  cause_o,  32'h00000034);
    check("unk_status", status_o, 32'h10000000);

    // exception beats a same-cycle EPC write; interrupt code 0
    we_i = 1'b1; waddr_i = 5'd14; data_i = 32'h1234;
    raise_exc(32'h1, 32'h400, 1'b0);
    we_i = 1'b0; waddr_i = 5'd0; data_i = 32'd0;
    check("int_epc",   epc_o,   32'h400);
    check("int_cause", cause_o, 32'h00000000);
    raise_exc(32'he, 32'h0, 1'b0);

    // PRId / Config writes ignored; Status full load
    cp0_write(5'd15, 32'hDEADBEEF);
    cp0_write(5'd16, 32'hDEADBEEF);
    check("prid_ro",   prid_o,   32'h004C0102);
    check("config_ro", config_o, 32'h00008000);
    cp0_write(5'd12, 32'h0000FF01);
    check("status_wr", status_o, 32'h0000FF01);

    // reset mid-operation clears a pending timer interrupt
    cp0_write(5'd11, 32'd7);
    cp0_write(5'd9, 32'd7);
    @(negedge clk);
    check("tmr_set_pre_rst", {31'd0, timer_int_o}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_timer",   {31'd0, timer_int_o}, 32'd0);
    check("mid_rst_status",  status_o,  32'h10000000);
    check("mid_rst_compare", compare_o, 32'h0);
    check("mid_rst_epc",     epc_o,     32'h0);
    rst = 1'b0;

    // Cause write: only IV/WP/IP[9:8]; IP[15:10] follows int_i
    int_i = 6'b101010;
    cp0_write(5'd13, 32'hFFFFFFFF);
    check("cause_wr", cause_o, 32'h00C0AB00);
    int_i = 6'd0;
    @(negedge clk);
    check("cause_int_follow", cause_o, 32'h00C00300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
